multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the 3-bit ALU operation code and ALU operand selects into the existing ALU, and consumes the ALU `zero` flag for branches. It is the issuing end of the ALU control interface and also produces all register, PC and memory enables, with wait-state handshaking to memory.

---
 rtl/mips_ctrl_pkg.sv | 49 ++++
 rtl/alu_funct_decoder.sv | 24 ++
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcode/funct constants and the ALU operation codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_funct_decoder.sv
// Maps an R-type funct field onto the ALU operation code; valid is low for
// funct values the datapath does not implement.
module alu_funct_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       valid
);

    always_comb begin
        valid       = 1'b1;
        alu_control = ALU_ADD;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath, with optional memory wait
// timeout (MEM_TIMEOUT) and optional bne support under `BNE_EN.
//
// state    | meaning
// FETCH    | read instruction, PC+4; waits for mem_ready
// DECODE   | compute branch target, dispatch on opcode
// MEMADR   | compute lw/sw effective address
// MEMRD    | data read; waits for mem_ready
// MEMWB    | write loaded data to register file
// MEMWR    | data write; waits for mem_ready
// RTYPE_EX | R-type ALU operation from funct
// RTYPE_WB | write R-type result to rd
// BRANCH   | compare operands, conditionally load branch target
// ADDI_EX  | A + immediate
// ADDI_WB  | write addi result to rt
// JUMP     | load jump target
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] wait_cnt;
    logic        mem_state;
    logic        timeout_hit;
    logic [2:0]  fn_alu;
    logic        fn_valid;

    alu_funct_decoder u_funct_dec (
        .funct       (funct),
        .alu_control (fn_alu),
        .valid       (fn_valid)
    );

    assign state = state_q;

    always_comb begin
        mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_ready
                      && (wait_cnt == 16'(MEM_TIMEOUT));
    end

    always_comb begin
        state_d     = state_q;
        alu_control = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        pc_src      = PCSRC_ALU;
        pc_en       = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                if (fn_valid) begin
                    alu_control = fn_alu;
                    state_d     = S_RTYPE_WB;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_RTYPE_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PCSRC_ALUOUT;
`ifdef BNE_EN
                pc_en       = (opcode == OP_BNE) ? ~zero : zero;
`else
                pc_en       = zero;
`endif
                state_d     = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = PCSRC_JUMP;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A stalled memory access is abandoned: strobes drop, selects stay.
        if (timeout_hit) begin
            pc_en       = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_timeout = 1'b1;
            state_d     = S_FETCH;
        end

        if (rst) begin
            pc_en       = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    // Only wait states hold the FSM, so "same state as next" means stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wait_cnt <= 16'd0;
        end else begin
            state_q <= state_d;
            if ((MEM_TIMEOUT != 0) && (state_d == state_q) && !timeout_hit)
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= 16'd0;
        end
    end

endmodule
